// File: rtl/trace_filter_ctrl_if.sv
// trace_filter_ctrl_if: config write bus, retired-instruction stream and filter control outputs
interface trace_filter_ctrl_if #(
  parameter int PC_WIDTH            = 64,
  parameter int ITEM_COUNT_WIDTH    = 32,
  parameter int RESYNC_PERIOD_WIDTH = 16,
  parameter int CFG_DATA_WIDTH      = 64
);
  logic                           cfg_wr_valid;
  logic                           cfg_wr_ready;
  logic [2:0]                     cfg_wr_addr;
  logic [CFG_DATA_WIDTH-1:0]      cfg_wr_data;
  logic                           pc_valid;
  logic [PC_WIDTH-1:0]            pc;
  logic                           drop_instr;
  logic                           trace_gate;
  logic [4:0]                     send_after_mask;
  logic                           resync_enable;
  logic [RESYNC_PERIOD_WIDTH-1:0] resync_period;
  logic [ITEM_COUNT_WIDTH-1:0]    item_count;
  logic [1:0]                     ctrl_state;

  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, pc_valid, pc, drop_instr,
    input  cfg_wr_ready, trace_gate, send_after_mask, resync_enable, resync_period,
           item_count, ctrl_state
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, pc_valid, pc, drop_instr,
    output cfg_wr_ready, trace_gate, send_after_mask, resync_enable, resync_period,
           item_count, ctrl_state
  );
endinterface

// File: rtl/trace_filter_ctrl.sv
// trace_filter_ctrl: shadow/active config with safe-boundary commit and IDLE/ARMED/ACTIVE/STOPPED run control
// Optional: define TRACE_CTRL_STOP_IRQ_EN to add a registered one-cycle stop_irq pulse on entry to STOPPED.
module trace_filter_ctrl #(
  parameter int PC_WIDTH            = 64,
  parameter int ITEM_COUNT_WIDTH    = 32,
  parameter int RESYNC_PERIOD_WIDTH = 16,
  parameter int CFG_DATA_WIDTH      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  trace_filter_ctrl_if.slave  bus
`ifdef TRACE_CTRL_STOP_IRQ_EN
  ,
  output logic                stop_irq
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2, STOPPED = 2'd3} state_t;

  state_t                         state_q, state_d;
  logic [8:0]                     ctrl_sh_q, ctrl_q;
  logic [PC_WIDTH-1:0]            start_sh_q, start_q, stop_sh_q, stop_q;
  logic [ITEM_COUNT_WIDTH-1:0]    limit_sh_q, limit_q, count_q, count_d, count_inc;
  logic [RESYNC_PERIOD_WIDTH-1:0] resync_sh_q, resync_q;
  logic                           commit_pending_q;
  logic                           wr_fire, commit_now, gate, kept, stop_hit;

  // no writes are accepted while a commit is waiting, so shadow is stable until it lands
  assign wr_fire    = bus.cfg_wr_valid && !commit_pending_q;
  // a commit must not split an instruction stream that is actively being traced
  assign commit_now = commit_pending_q && (!bus.pc_valid || state_q != ACTIVE);

  // shadow config registers, written by software
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_sh_q   <= '0;
      start_sh_q  <= '0;
      stop_sh_q   <= '0;
      limit_sh_q  <= '0;
      resync_sh_q <= '0;
    end else if (wr_fire) begin
      case (bus.cfg_wr_addr)
        3'd0:    ctrl_sh_q   <= bus.cfg_wr_data[8:0];
        3'd1:    start_sh_q  <= bus.cfg_wr_data[PC_WIDTH-1:0];
        3'd2:    stop_sh_q   <= bus.cfg_wr_data[PC_WIDTH-1:0];
        3'd3:    limit_sh_q  <= bus.cfg_wr_data[ITEM_COUNT_WIDTH-1:0];
        3'd4:    resync_sh_q <= bus.cfg_wr_data[RESYNC_PERIOD_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // commit request flag, set by a COMMIT write and cleared when the commit applies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) commit_pending_q <= 1'b0;
    else if (commit_now) commit_pending_q <= 1'b0;
    else if (wr_fire && bus.cfg_wr_addr == 3'd7) commit_pending_q <= 1'b1;
  end

  // active config, copied from shadow only in the commit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      limit_q  <= '0;
      resync_q <= '0;
    end else if (commit_now) begin
      ctrl_q   <= ctrl_sh_q;
      start_q  <= start_sh_q;
      stop_q   <= stop_sh_q;
      limit_q  <= limit_sh_q;
      resync_q <= resync_sh_q;
    end
  end

  // gate, kept-item and stop decisions for the current instruction
  always_comb begin
    gate      = state_q == ACTIVE || (state_q == ARMED && bus.pc_valid && bus.pc == start_q);
    kept      = bus.pc_valid && gate && !bus.drop_instr;
    count_inc = (kept && !(&count_q)) ? count_q + ITEM_COUNT_WIDTH'(1) : count_q;
    stop_hit  = (ctrl_q[2] && bus.pc_valid && gate && bus.pc == stop_q) ||
                (kept && limit_q != '0 && count_inc == limit_q);
  end

  // run-control next state and kept-item counter
  always_comb begin
    state_d = state_q;
    count_d = count_inc;
    if (commit_now) begin
      state_d = ctrl_sh_q[0] ? (ctrl_sh_q[1] ? ARMED : ACTIVE) : IDLE;
      count_d = ctrl_sh_q[0] ? '0 : count_q;
    end else if (gate) begin
      state_d = stop_hit ? STOPPED : ACTIVE;
    end
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef TRACE_CTRL_STOP_IRQ_EN
  logic was_stopped_q, stop_irq_q;

  // pulse one cycle after the state register first shows STOPPED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      was_stopped_q <= 1'b0;
      stop_irq_q    <= 1'b0;
    end else begin
      was_stopped_q <= state_q == STOPPED;
      stop_irq_q    <= state_q == STOPPED && !was_stopped_q;
    end
  end

  assign stop_irq = stop_irq_q;
`endif

  assign bus.cfg_wr_ready    = !commit_pending_q;
  assign bus.trace_gate      = gate;
  assign bus.send_after_mask = ctrl_q[7:3];
  assign bus.resync_enable   = ctrl_q[8];
  assign bus.resync_period   = resync_q;
  assign bus.item_count      = count_q;
  assign bus.ctrl_state      = state_q;
endmodule

// File: tb/tb_trace_filter_ctrl.sv
// tb_trace_filter_ctrl: directed checks of commit timing, triggers, item limit and reset
module tb_trace_filter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  trace_filter_ctrl_if bus ();
`ifdef TRACE_CTRL_STOP_IRQ_EN
  logic stop_irq;
`endif

  trace_filter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef TRACE_CTRL_STOP_IRQ_EN
    ,
    .stop_irq (stop_irq)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    int n = 0;
    while (!bus.cfg_wr_ready && n < 50) begin
      tick;
      n++;
    end
    if (n == 50) chk("wr_ready_timeout", {63'd0, bus.cfg_wr_ready}, 64'd1);
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_addr  = a;
    bus.cfg_wr_data  = d;
    tick;
    bus.cfg_wr_valid = 1'b0;
  endtask

  task automatic commit;
    wr(3'd7, 64'd0);
    tick;
  endtask

  task automatic instr(input logic [63:0] p, input logic d);
    bus.pc_valid   = 1'b1;
    bus.pc         = p;
    bus.drop_instr = d;
    #1;
  endtask

  logic [63:0] pcs [5] = '{64'hFF0, 64'h1000, 64'h1004, 64'h1010, 64'h1014};
  logic        gexp [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        drops [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        lgate [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] lcnt [4] = '{32'd0, 32'd1, 32'd2, 32'd2};

  initial begin
    bus.cfg_wr_valid = 1'b0;
    bus.cfg_wr_addr  = '0;
    bus.cfg_wr_data  = '0;
    bus.pc_valid     = 1'b0;
    bus.pc           = '0;
    bus.drop_instr   = 1'b0;
    #7;
    chk("rst_state", bus.ctrl_state, 0);
    chk("rst_gate", bus.trace_gate, 0);
    chk("rst_count", bus.item_count, 0);
    chk("rst_ready", bus.cfg_wr_ready, 1);
    chk("rst_period", bus.resync_period, 0);
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("rst_irq", stop_irq, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // start/stop triggers
    wr(3'd0, 64'h7);
    wr(3'd1, 64'h1000);
    wr(3'd2, 64'h1010);
    commit;
    chk("ss_armed", bus.ctrl_state, 1);
    chk("ss_ready", bus.cfg_wr_ready, 1);
    for (int i = 0; i < 5; i++) begin
      instr(pcs[i], 1'b0);
      chk($sformatf("ss_gate%0d", i), bus.trace_gate, gexp[i]);
      tick;
      if (i == 1) chk("ss_active", bus.ctrl_state, 2);
    end
    bus.pc_valid = 1'b0;
    chk("ss_count", bus.item_count, 3);
    chk("ss_stopped", bus.ctrl_state, 3);

    // item limit with a dropped first instruction
    wr(3'd0, 64'h1);
    wr(3'd3, 64'd2);
    commit;
    chk("lim_active", bus.ctrl_state, 2);
    chk("lim_count0", bus.item_count, 0);
    for (int i = 0; i < 4; i++) begin
      instr(64'h4000 + 64'(4 * i), drops[i]);
      chk($sformatf("lim_gate%0d", i), bus.trace_gate, lgate[i]);
      tick;
      chk($sformatf("lim_count%0d", i), bus.item_count, lcnt[i]);
`ifdef TRACE_CTRL_STOP_IRQ_EN
      chk($sformatf("lim_irq%0d", i), stop_irq, i == 3);
`endif
      if (i == 2) chk("lim_stopped", bus.ctrl_state, 3);
    end
    bus.pc_valid = 1'b0;
    tick;
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("lim_irq_end", stop_irq, 0);
`endif
    chk("lim_hold", bus.item_count, 2);

    // deferred commit under a continuous instruction stream
    wr(3'd3, 64'd0);
    wr(3'd4, 64'h10);
    wr(3'd0, 64'h1A9);
    commit;
    chk("def_state", bus.ctrl_state, 2);
    chk("def_mask", bus.send_after_mask, 5'h15);
    chk("def_rsen", bus.resync_enable, 1);
    chk("def_period0", bus.resync_period, 16'h10);
    instr(64'h3000, 1'b0);
    wr(3'd4, 64'h40);
    wr(3'd7, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("def_ready%0d", i), bus.cfg_wr_ready, 0);
      chk($sformatf("def_period%0d", i), bus.resync_period, 16'h10);
      tick;
    end
    chk("def_count", bus.item_count, 10);
    bus.pc_valid = 1'b0;
    #1;
    chk("def_ready_gap", bus.cfg_wr_ready, 0);
    tick;
    chk("def_period_new", bus.resync_period, 16'h40);
    chk("def_ready_back", bus.cfg_wr_ready, 1);
    chk("def_count_clr", bus.item_count, 0);
    chk("def_state_new", bus.ctrl_state, 2);

    // start and stop on the same instruction
    wr(3'd1, 64'h2000);
    wr(3'd2, 64'h2000);
    wr(3'd0, 64'h7);
    commit;
    chk("same_armed", bus.ctrl_state, 1);
    chk("same_mask", bus.send_after_mask, 0);
    instr(64'h1FFC, 1'b0);
    chk("same_gate0", bus.trace_gate, 0);
    tick;
    chk("same_still_armed", bus.ctrl_state, 1);
    instr(64'h2000, 1'b0);
    chk("same_gate1", bus.trace_gate, 1);
    tick;
    chk("same_stopped", bus.ctrl_state, 3);
    chk("same_count", bus.item_count, 1);
    instr(64'h2004, 1'b0);
    chk("same_gate2", bus.trace_gate, 0);
    tick;
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("same_irq", stop_irq, 1);
`endif
    bus.pc_valid = 1'b0;
    tick;
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("same_irq_end", stop_irq, 0);
`endif

    // commit with enable cleared returns to IDLE, count held
    wr(3'd0, 64'h0);
    commit;
    chk("dis_idle", bus.ctrl_state, 0);
    chk("dis_count", bus.item_count, 1);
    instr(64'h2000, 1'b0);
    chk("dis_gate", bus.trace_gate, 0);
    tick;
    chk("dis_count_hold", bus.item_count, 1);
    bus.pc_valid = 1'b0;

    // limit of one, second stop pulse after re-arm
    wr(3'd0, 64'h1);
    wr(3'd3, 64'd1);
    commit;
    chk("l1_active", bus.ctrl_state, 2);
    instr(64'h5000, 1'b0);
    tick;
    bus.pc_valid = 1'b0;
    chk("l1_stopped", bus.ctrl_state, 3);
    chk("l1_count", bus.item_count, 1);
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("l1_irq_pre", stop_irq, 0);
`endif
    tick;
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("l1_irq", stop_irq, 1);
`endif
    tick;
`ifdef TRACE_CTRL_STOP_IRQ_EN
    chk("l1_irq_end", stop_irq, 0);
`endif

    // asynchronous reset in the middle of ACTIVE
    wr(3'd3, 64'd0);
    commit;
    for (int i = 0; i < 5; i++) begin
      instr(64'h6000 + 64'(4 * i), 1'b0);
      tick;
    end
    chk("mid_count", bus.item_count, 5);
    chk("mid_state", bus.ctrl_state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", bus.ctrl_state, 0);
    chk("mid_rst_gate", bus.trace_gate, 0);
    chk("mid_rst_count", bus.item_count, 0);
    chk("mid_rst_ready", bus.cfg_wr_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
